doc_port_arbiter: RTL
=====================

# doc_port_arbiter

Shares the single read/write port of the `document` character RAM among three requesters: the text editor's recognized-character writes, the UART messenger's sequential reads, and a built-in clear sweep that fills every cell with a blank code. It sits between `text_editor`/`messenger` and `document` port A. It replaces the ad-hoc address muxing so that a send, a recognizer commit and a clear can overlap without corrupting each other.

## Interface
- `ADDR_W`, 9: document address width.
- `DATA_W`, 8: character code width.
- `DEPTH`, 300: number of cells swept by a clear (20 columns × 15 rows); must be ≤ 2^ADDR_W.
- `FILL`, 8'h00: code written to every cell by a clear.

- `clk` in 1: system clock; the only clock.
- `rst` in 1: reset, asynchronous, active-low.
- `clr_start` in 1: one-cycle pulse that requests a full clear.
- `clr_busy` out 1: clear sweep in progress.
- `clr_done` out 1: one-cycle pulse after the last fill write.
- `wr_req` in 1: editor write request; held until acknowledged.
- `wr_addr` in ADDR_W: editor write address.
- `wr_data` in DATA_W: editor write data.
- `wr_ack` out 1: write performed this cycle.
- `rd_req` in 1: messenger read request; held until acknowledged.
- `rd_addr` in ADDR_W: messenger read address.
- `rd_ack` out 1: read address presented to RAM this cycle.
- `rd_data` out DATA_W: registered read data.
- `rd_valid` out 1: `rd_data` valid; one-cycle pulse.
- `mem_a` out ADDR_W: RAM port address.
- `mem_d` out DATA_W: RAM write data.
- `mem_we` out 1: RAM write enable.
- `mem_q` in DATA_W: RAM asynchronous read data (`spo`).

## Operation
- States: `IDLE`, `CLEAR`.
- `IDLE` + `clr_start` → `CLEAR` on the next edge, with the sweep counter at 0. `clr_start` in `CLEAR` is ignored.
- `CLEAR`: each cycle `mem_a` = counter, `mem_d` = `FILL`, `mem_we` = 1, and the counter is incremented. At counter = `DEPTH-1` the FSM goes → `IDLE`, and `clr_done` pulses in the first `IDLE` cycle. There is no wrap past `DEPTH-1`.
- In `CLEAR`, `wr_ack` and `rd_ack` are 0. Requests are stalled, not dropped, and are served after the sweep.
- In `IDLE`, at most one grant per cycle:
  - Only one of `wr_req`/`rd_req` asserted: that one is granted.
  - Both asserted: round-robin. A `last_wr` flag selects read if the last grant was a write, otherwise write. `last_wr` resets to 0, so write wins the first conflict.
- Write grant: `mem_a` = `wr_addr`, `mem_d` = `wr_data`, `mem_we` = 1, `wr_ack` = 1 (combinational, same cycle).
- Read grant: `mem_a` = `rd_addr`, `mem_we` = 0, `rd_ack` = 1. `mem_q` is registered into `rd_data` at the edge, and `rd_valid` = 1 the next cycle.
- No grant: `mem_a` = 0, `mem_d` = 0, `mem_we` = 0.
- Requesters keep addr/data stable while `req` is high and not yet acked. Keeping `req` high after an ack issues a new request; back-to-back grants are allowed.
- Reset (any time, including mid-sweep): FSM `IDLE`, counter 0, `last_wr` 0, `rd_data` 0. All outputs are 0: `clr_busy`, `clr_done`, `rd_valid`, `wr_ack`, `rd_ack`, `mem_we`. A partially completed clear is abandoned, not resumed.

## Timing
- Clear: `clr_start` at cycle 0. `clr_busy` = 1 in cycles 1..`DEPTH`, with fill writes in cycles 1..`DEPTH`. `clr_done` pulses in cycle `DEPTH+1`.
- Write latency: 0 cycles from grant to RAM write. `wr_ack` is in the grant cycle.
- Read latency: `rd_valid` and `rd_data` arrive 1 cycle after `rd_ack`.
- Worst-case wait in `IDLE` with both requesters continuously active is 1 cycle.
- `clr_start` coinciding with a grant in `IDLE`: that grant completes this cycle and the sweep starts the next cycle.
- `clr_busy`, `clr_done`, `rd_data` and `rd_valid` are registered. `mem_*`, `wr_ack` and `rd_ack` are combinational from state and requests.

## Structure
- Shared package `doc_pkg`:
  - FSM state enum (`IDLE`, `CLEAR`).
  - `DOC_COLS` = 20, `DOC_ROWS` = 15, `DOC_DEPTH` = 300.
  - Blank character code.
- Sub-module `doc_clear_sweep`: counter, `clr_busy` and `clr_done`, with `start` and `busy` ports. The grant mux and round-robin flag stay in the top level.

## Test plan
- Single write: `wr_req`, `wr_addr` = 9'd37, `wr_data` = 8'h41 → `wr_ack` and `mem_we` high the same cycle with `mem_a` = 37 and `mem_d` = 8'h41; a model RAM holds 8'h41 at 37.
- Single read: RAM[5] = 8'h7A, `rd_req`, `rd_addr` = 5 → `rd_ack` at cycle t, then `rd_valid` and `rd_data` = 8'h7A at t+1.
- Conflict: `wr_req` and `rd_req` both held for 4 grants → grant order W, R, W, R, with no cycle left idle.
- Clear: `clr_start` pulse → exactly 300 writes of 8'h00 to addresses 0..299 in order. `clr_busy` is high for 300 cycles and `clr_done` pulses once. A `wr_req` raised mid-sweep is acked in the cycle of `clr_done`.
- Reset mid-sweep: `rst` low at sweep address 120 → all outputs 0 immediately (asynchronously). After release there are no further fill writes, and addresses 120..299 keep their old contents.
- `clr_start` in `CLEAR` at address 50 → ignored: still a single sweep ending at 299 and a single `clr_done`.

Source files
------------

// File: rtl/doc_pkg.sv
// Shared definitions for the document character RAM and its port arbiter.
//   DOC_COLS x DOC_ROWS cells, DOC_ADDR_W-bit address, DOC_DATA_W-bit codes,
//   DOC_BLANK is the code a clear writes, doc_state_e is the arbiter FSM state.
package doc_pkg;

    localparam int unsigned DOC_COLS   = 20;
    localparam int unsigned DOC_ROWS   = 15;
    localparam int unsigned DOC_DEPTH  = DOC_COLS * DOC_ROWS;
    localparam int unsigned DOC_ADDR_W = 9;
    localparam int unsigned DOC_DATA_W = 8;

    localparam logic [DOC_DATA_W-1:0] DOC_BLANK = 8'h00;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } doc_state_e;

endpackage

// File: rtl/doc_clear_sweep.sv
// Clear sweep sequencer: walks addresses 0..DEPTH-1, one per cycle, after a start pulse.
//   clk, rst (async, active-low)
//   start : one-cycle request, ignored while a sweep is running
//   busy  : registered, high on every sweep cycle (one fill write per cycle)
//   done  : registered one-cycle pulse in the first idle cycle after the last fill
//   addr  : current sweep address
module doc_clear_sweep
    import doc_pkg::*;
#(
    parameter int unsigned ADDR_W = DOC_ADDR_W,
    parameter int unsigned DEPTH  = DOC_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] addr
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    doc_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state and sweep counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Registered outputs, computed from the upcoming state
    always_comb begin
        busy_d = (state_d == CLEAR);
        done_d = (state_q == CLEAR) && (state_d == IDLE);
    end

    assign busy = busy_q;
    assign done = done_q;
    assign addr = cnt_q;

endmodule

// File: rtl/doc_port_arbiter.sv
// Shares document RAM port A between editor writes, messenger reads and a clear sweep.
//   clk, rst (async, active-low)
//   clr_start/clr_busy/clr_done          : clear request, sweep in progress, completion pulse
//   wr_req/wr_addr/wr_data/wr_ack        : editor write, acked in the cycle it hits the RAM
//   rd_req/rd_addr/rd_ack/rd_data/rd_valid : messenger read, data registered one cycle after ack
//   mem_a/mem_d/mem_we/mem_q             : RAM port (mem_q is the asynchronous read data)
module doc_port_arbiter
    import doc_pkg::*;
#(
    parameter int unsigned       ADDR_W = DOC_ADDR_W,
    parameter int unsigned       DATA_W = DOC_DATA_W,
    parameter int unsigned       DEPTH  = DOC_DEPTH,
    parameter logic [DATA_W-1:0] FILL   = DATA_W'(DOC_BLANK)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_d,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_q
);

    logic              sweep_busy;
    logic [ADDR_W-1:0] sweep_addr;

    logic              wr_gnt, rd_gnt;
    logic              last_wr_q, last_wr_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;

    doc_clear_sweep #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_sweep (
        .clk   (clk),
        .rst   (rst),
        .start (clr_start),
        .busy  (sweep_busy),
        .done  (clr_done),
        .addr  (sweep_addr)
    );

    // Grant selection; rst gating keeps the combinational acks low while reset is held
    always_comb begin
        wr_gnt = 1'b0;
        rd_gnt = 1'b0;
        if (rst && !sweep_busy) begin
            wr_gnt = wr_req && (!rd_req || !last_wr_q);
            rd_gnt = rd_req && (!wr_req ||  last_wr_q);
        end
    end

    // RAM port mux; the sweep owns the port whenever it runs
    always_comb begin
        mem_a  = '0;
        mem_d  = '0;
        mem_we = 1'b0;
        if (sweep_busy) begin
            mem_a  = sweep_addr;
            mem_d  = FILL;
            mem_we = 1'b1;
        end else if (wr_gnt) begin
            mem_a  = wr_addr;
            mem_d  = wr_data;
            mem_we = 1'b1;
        end else if (rd_gnt) begin
            mem_a = rd_addr;
        end
    end

    // Round-robin flag and read data capture
    always_comb begin
        last_wr_d  = last_wr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_gnt;
        if (wr_gnt) begin
            last_wr_d = 1'b1;
        end else if (rd_gnt) begin
            last_wr_d = 1'b0;
            rd_data_d = mem_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_wr_q  <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            last_wr_q  <= last_wr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign wr_ack   = wr_gnt;
    assign rd_ack   = rd_gnt;
    assign clr_busy = sweep_busy;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule
